id_ex_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU in the 16-bit pipelined datapath.

---
 rtl/id_ex_stage_pkg.sv | 20 ++
 rtl/id_ex_stage_if.sv | 66 ++++++
 rtl/id_ex_stage_ex_fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op encodings and
// default datapath widths.
package id_ex_stage_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_REG_BITS = 3;
  localparam int DEF_OP_BITS  = 3;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_SLL = 3'd1,
    OP_ROR = 3'd2,
    OP_SRA = 3'd3,
    OP_ADD = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_AND = 3'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, forwarding sources and EX-side outputs of the
// ID/EX stage.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int OP_BITS  = DEF_OP_BITS
);
  // Handshake: in_valid marks a live instruction; there is no ready. The
  // stage always accepts unless stall is high, in which case the decode side
  // must keep presenting the same instruction; flush turns the next EX slot
  // into a bubble regardless of stall.
  logic                in_valid;
  logic                stall;
  logic                flush;
  logic [OP_BITS-1:0]  id_op;
  logic                id_inv_a;
  logic                id_inv_b;
  logic                id_sign;
  logic                id_cin;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic [REG_BITS-1:0] id_rd;
  logic                id_wr_en;
  logic [WIDTH-1:0]    id_rs_data;
  logic [WIDTH-1:0]    id_rt_data;
  logic [WIDTH-1:0]    id_imm;
  logic                id_use_imm;
  logic                exm_wr_en;
  logic [REG_BITS-1:0] exm_rd;
  logic [WIDTH-1:0]    exm_result;
  logic                mw_wr_en;
  logic [REG_BITS-1:0] mw_rd;
  logic [WIDTH-1:0]    mw_result;

  logic                ex_valid;
  logic [WIDTH-1:0]    ex_a;
  logic [WIDTH-1:0]    ex_b;
  logic [OP_BITS-1:0]  ex_op;
  logic                ex_inv_a;
  logic                ex_inv_b;
  logic                ex_sign;
  logic                ex_cin;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_wr_en;

  modport master (
    output in_valid, stall, flush, id_op, id_inv_a, id_inv_b, id_sign, id_cin,
           id_rs, id_rt, id_rd, id_wr_en, id_rs_data, id_rt_data, id_imm,
           id_use_imm, exm_wr_en, exm_rd, exm_result, mw_wr_en, mw_rd,
           mw_result,
    input  ex_valid, ex_a, ex_b, ex_op, ex_inv_a, ex_inv_b, ex_sign, ex_cin,
           ex_rd, ex_wr_en
  );

  modport slave (
    input  in_valid, stall, flush, id_op, id_inv_a, id_inv_b, id_sign, id_cin,
           id_rs, id_rt, id_rd, id_wr_en, id_rs_data, id_rt_data, id_imm,
           id_use_imm, exm_wr_en, exm_rd, exm_result, mw_wr_en, mw_rd,
           mw_result,
    output ex_valid, ex_a, ex_b, ex_op, ex_inv_a, ex_inv_b, ex_sign, ex_cin,
           ex_rd, ex_wr_en
  );

endinterface

// File: rtl/id_ex_stage_ex_fwd_mux.sv
// Three-way operand select: EX/MEM result, then MEM/WB result, then the
// register-file read. The youngest matching producer wins.
module id_ex_stage_ex_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic [REG_BITS-1:0] src_rd,
  input  logic [WIDTH-1:0]    rf_data,
  input  logic                exm_wr_en,
  input  logic [REG_BITS-1:0] exm_rd,
  input  logic [WIDTH-1:0]    exm_result,
  input  logic                mw_wr_en,
  input  logic [REG_BITS-1:0] mw_rd,
  input  logic [WIDTH-1:0]    mw_result,
  output logic [WIDTH-1:0]    fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    if (exm_wr_en && (exm_rd == src_rd)) begin
      fwd_data = exm_result;
    end else if (mw_wr_en && (mw_rd == src_rd)) begin
      fwd_data = mw_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures ALU controls and forwarded operands,
// with priority rst > flush > stall > capture.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int OP_BITS  = DEF_OP_BITS
) (
  input logic            clk,
  input logic            rst,
  id_ex_stage_if.slave   bus
);

  logic [WIDTH-1:0]    fwd_a;
  logic [WIDTH-1:0]    fwd_b;

  logic                ex_valid_d, ex_valid_q;
  logic [WIDTH-1:0]    ex_a_d, ex_a_q;
  logic [WIDTH-1:0]    ex_b_d, ex_b_q;
  logic [OP_BITS-1:0]  ex_op_d, ex_op_q;
  logic                ex_inv_a_d, ex_inv_a_q;
  logic                ex_inv_b_d, ex_inv_b_q;
  logic                ex_sign_d, ex_sign_q;
  logic                ex_cin_d, ex_cin_q;
  logic [REG_BITS-1:0] ex_rd_d, ex_rd_q;
  logic                ex_wr_en_d, ex_wr_en_q;

  id_ex_stage_ex_fwd_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_a (
    .src_rd     (bus.id_rs),
    .rf_data    (bus.id_rs_data),
    .exm_wr_en  (bus.exm_wr_en),
    .exm_rd     (bus.exm_rd),
    .exm_result (bus.exm_result),
    .mw_wr_en   (bus.mw_wr_en),
    .mw_rd      (bus.mw_rd),
    .mw_result  (bus.mw_result),
    .fwd_data   (fwd_a)
  );

  id_ex_stage_ex_fwd_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_b (
    .src_rd     (bus.id_rt),
    .rf_data    (bus.id_rt_data),
    .exm_wr_en  (bus.exm_wr_en),
    .exm_rd     (bus.exm_rd),
    .exm_result (bus.exm_result),
    .mw_wr_en   (bus.mw_wr_en),
    .mw_rd      (bus.mw_rd),
    .mw_result  (bus.mw_result),
    .fwd_data   (fwd_b)
  );

  always_comb begin
    // Default: bubble (flush); the same values as reset.
    ex_valid_d = 1'b0;
    ex_a_d     = '0;
    ex_b_d     = '0;
    ex_op_d    = OP_BITS'(OP_ROL);
    ex_inv_a_d = 1'b0;
    ex_inv_b_d = 1'b0;
    ex_sign_d  = 1'b0;
    ex_cin_d   = 1'b0;
    ex_rd_d    = '0;
    ex_wr_en_d = 1'b0;
    if (!bus.flush) begin
      if (bus.stall) begin
        ex_valid_d = ex_valid_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_op_d    = ex_op_q;
        ex_inv_a_d = ex_inv_a_q;
        ex_inv_b_d = ex_inv_b_q;
        ex_sign_d  = ex_sign_q;
        ex_cin_d   = ex_cin_q;
        ex_rd_d    = ex_rd_q;
        ex_wr_en_d = ex_wr_en_q;
      end else begin
        // Fields are captured even for an invalid slot; only the write
        // enable is qualified so a dead slot can never retire a write.
        ex_valid_d = bus.in_valid;
        ex_a_d     = fwd_a;
        ex_b_d     = bus.id_use_imm ? bus.id_imm : fwd_b;
        ex_op_d    = bus.id_op;
        ex_inv_a_d = bus.id_inv_a;
        ex_inv_b_d = bus.id_inv_b;
        ex_sign_d  = bus.id_sign;
        ex_cin_d   = bus.id_cin;
        ex_rd_d    = bus.id_rd;
        ex_wr_en_d = bus.id_wr_en & bus.in_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_op_q    <= OP_BITS'(OP_ROL);
      ex_inv_a_q <= 1'b0;
      ex_inv_b_q <= 1'b0;
      ex_sign_q  <= 1'b0;
      ex_cin_q   <= 1'b0;
      ex_rd_q    <= '0;
      ex_wr_en_q <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_op_q    <= ex_op_d;
      ex_inv_a_q <= ex_inv_a_d;
      ex_inv_b_q <= ex_inv_b_d;
      ex_sign_q  <= ex_sign_d;
      ex_cin_q   <= ex_cin_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_en_q <= ex_wr_en_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_inv_a = ex_inv_a_q;
  assign bus.ex_inv_b = ex_inv_b_q;
  assign bus.ex_sign  = ex_sign_q;
  assign bus.ex_cin   = ex_cin_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_wr_en = ex_wr_en_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, forwarding priority,
// immediate select, stall/flush and an end-to-end ALU shift.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Reference ALU used only for the end-to-end shift check.
  function automatic logic [15:0] alu_ref(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd3:    r = 16'($signed(a) >>> b[3:0]);
      3'd4:    r = a + b;
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.id_op      = 3'd0;
    bus.id_inv_a   = 1'b0;
    bus.id_inv_b   = 1'b0;
    bus.id_sign    = 1'b0;
    bus.id_cin     = 1'b0;
    bus.id_rs      = 3'd0;
    bus.id_rt      = 3'd0;
    bus.id_rd      = 3'd0;
    bus.id_wr_en   = 1'b0;
    bus.id_rs_data = 16'h0;
    bus.id_rt_data = 16'h0;
    bus.id_imm     = 16'h0;
    bus.id_use_imm = 1'b0;
    bus.exm_wr_en  = 1'b0;
    bus.exm_rd     = 3'd0;
    bus.exm_result = 16'h0;
    bus.mw_wr_en   = 1'b0;
    bus.mw_rd      = 3'd0;
    bus.mw_result  = 16'h0;
  endtask

  task automatic random_inputs();
    bus.in_valid   = 1'($urandom_range(0, 1));
    bus.stall      = 1'($urandom_range(0, 1));
    bus.flush      = 1'($urandom_range(0, 1));
    bus.id_op      = 3'($urandom_range(0, 7));
    bus.id_inv_a   = 1'($urandom_range(0, 1));
    bus.id_inv_b   = 1'($urandom_range(0, 1));
    bus.id_sign    = 1'($urandom_range(0, 1));
    bus.id_cin     = 1'($urandom_range(0, 1));
    bus.id_rs      = 3'($urandom_range(0, 7));
    bus.id_rt      = 3'($urandom_range(0, 7));
    bus.id_rd      = 3'($urandom_range(0, 7));
    bus.id_wr_en   = 1'($urandom_range(0, 1));
    bus.id_rs_data = 16'($urandom_range(0, 65535));
    bus.id_rt_data = 16'($urandom_range(0, 65535));
    bus.id_imm     = 16'($urandom_range(0, 65535));
    bus.id_use_imm = 1'($urandom_range(0, 1));
    bus.exm_wr_en  = 1'($urandom_range(0, 1));
    bus.exm_rd     = 3'($urandom_range(0, 7));
    bus.exm_result = 16'($urandom_range(0, 65535));
    bus.mw_wr_en   = 1'($urandom_range(0, 1));
    bus.mw_rd      = 3'($urandom_range(0, 7));
    bus.mw_result  = 16'($urandom_range(0, 65535));
  endtask

  // Advance one rising edge and settle, so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 16'(bus.ex_valid), 16'h0);
    check({tag, "_a"},     bus.ex_a,          16'h0);
    check({tag, "_b"},     bus.ex_b,          16'h0);
    check({tag, "_op"},    16'(bus.ex_op),    16'h0);
    check({tag, "_ctl"},   16'({bus.ex_inv_a, bus.ex_inv_b, bus.ex_sign, bus.ex_cin}), 16'h0);
    check({tag, "_rd"},    16'(bus.ex_rd),    16'h0);
    check({tag, "_wr_en"}, 16'(bus.ex_wr_en), 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();

    // 1: reset with random inputs, then a plain ADD capture
    rst = 1'b1;
    random_inputs();
    step();
    random_inputs();
    step();
    check_all_zero("rst");
    rst = 1'b0;
    clear_inputs();
    bus.in_valid   = 1'b1;
    bus.id_op      = OP_ADD;
    bus.id_rs      = 3'd1;
    bus.id_rt      = 3'd2;
    bus.id_rd      = 3'd6;
    bus.id_wr_en   = 1'b1;
    bus.id_inv_b   = 1'b1;
    bus.id_cin     = 1'b1;
    bus.id_rs_data = 16'h0123;
    bus.id_rt_data = 16'h0234;
    step();
    check("add_a",     bus.ex_a,          16'h0123);
    check("add_b",     bus.ex_b,          16'h0234);
    check("add_op",    16'(bus.ex_op),    16'd4);
    check("add_valid", 16'(bus.ex_valid), 16'h1);
    check("add_rd",    16'(bus.ex_rd),    16'd6);
    check("add_wr_en", 16'(bus.ex_wr_en), 16'h1);
    check("add_ctl",   16'({bus.ex_inv_a, bus.ex_inv_b, bus.ex_sign, bus.ex_cin}), 16'b0101);

    // 2: EX/MEM beats MEM/WB, then MEM/WB alone
    bus.id_rs      = 3'd3;
    bus.exm_wr_en  = 1'b1;
    bus.exm_rd     = 3'd3;
    bus.exm_result = 16'hBEEF;
    bus.mw_wr_en   = 1'b1;
    bus.mw_rd      = 3'd3;
    bus.mw_result  = 16'h1111;
    step();
    check("fwd_exm_a", bus.ex_a, 16'hBEEF);
    check("fwd_exm_b_nomatch", bus.ex_b, 16'h0234);
    bus.exm_wr_en = 1'b0;
    step();
    check("fwd_mw_a", bus.ex_a, 16'h1111);
    // MEM/WB to B while A has no match
    bus.id_rs = 3'd1;
    bus.id_rt = 3'd3;
    step();
    check("fwd_mw_b", bus.ex_b, 16'h1111);
    check("fwd_mw_a_rf", bus.ex_a, 16'h0123);
    // Matching rd but write enable low on both: register file value
    bus.mw_wr_en = 1'b0;
    bus.exm_rd   = 3'd3;
    step();
    check("fwd_none_b", bus.ex_b, 16'h0234);

    // 3: immediate overrides a matching EX/MEM producer on B
    bus.exm_wr_en  = 1'b1;
    bus.exm_rd     = 3'd3;
    bus.id_use_imm = 1'b1;
    bus.id_imm     = 16'hFFF6;
    step();
    check("imm_b", bus.ex_b, 16'hFFF6);
    clear_inputs();

    // 4: stall holds for 3 cycles, release captures the new value
    bus.in_valid   = 1'b1;
    bus.id_op      = OP_OR;
    bus.id_rs_data = 16'h0018;
    bus.id_rt_data = 16'h0018;
    step();
    check("cap_a", bus.ex_a, 16'h0018);
    bus.stall      = 1'b1;
    bus.id_op      = OP_XOR;
    bus.id_rs_data = 16'h00EA;
    bus.id_rt_data = 16'h00EA;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_a",  bus.ex_a,       16'h0018);
      check("stall_op", 16'(bus.ex_op), 16'd5);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_a",  bus.ex_a,       16'h00EA);
    check("unstall_b",  bus.ex_b,       16'h00EA);
    check("unstall_op", 16'(bus.ex_op), 16'd6);

    // 5: flush wins over stall; invalid slot drops the write
    bus.id_wr_en = 1'b1;
    bus.id_rd    = 3'd4;
    step();
    check("pre_flush_wr_en", 16'(bus.ex_wr_en), 16'h1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    check_all_zero("flush");
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.id_rs_data = 16'h5A5A;
    step();
    check("inv_wr_en", 16'(bus.ex_wr_en), 16'h0);
    check("inv_valid", 16'(bus.ex_valid), 16'h0);
    check("inv_a",     bus.ex_a,          16'h5A5A);
    check("inv_rd",    16'(bus.ex_rd),    16'd4);
    clear_inputs();

    // 6: SRA end-to-end through a reference ALU
    bus.in_valid   = 1'b1;
    bus.id_op      = OP_SRA;
    bus.id_rs_data = 16'hFA7B;
    bus.id_use_imm = 1'b1;
    bus.id_imm     = 16'h0004;
    step();
    check("sra_a",   bus.ex_a, 16'hFA7B);
    check("sra_b",   bus.ex_b, 16'h0004);
    check("sra_alu", alu_ref(bus.ex_op, bus.ex_a, bus.ex_b), 16'hFFA7);

    // Reset mid-stream clears a live stage
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
